// File: rtl/finalproject_pkg.sv
// Shared constants for the final-project draw pipeline: arbiter state
// encoding, VGA coordinate/colour widths and the default watchdog limit.
package finalproject_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam int PIX_X_W = 8;
  localparam int PIX_Y_W = 7;
  localparam int PIX_C_W = 3;

  localparam int DEF_MAX_HOLD = 1024;

endpackage

// File: rtl/plot_arbiter_if.sv
// Bundle between the draw engines (master side) and plot_arbiter (slave side),
// including the forwarded pixel stream headed for vga_adapter.
interface plot_arbiter_if
  import finalproject_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = PIX_X_W,
  parameter int Y_W   = PIX_Y_W,
  parameter int C_W   = PIX_C_W
);

  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     done;
  logic [N_REQ*X_W-1:0] px;
  logic [N_REQ*Y_W-1:0] py;
  logic [N_REQ*C_W-1:0] pcol;
  logic [N_REQ-1:0]     pplot;

  logic [N_REQ-1:0]     gnt;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [C_W-1:0]       colour;
  logic                 plot;
  logic                 timeout;

  modport master (
    output req, done, px, py, pcol, pplot,
    input  gnt, owner, busy, x, y, colour, plot, timeout
  );

  modport slave (
    input  req, done, px, py, pcol, pplot,
    output gnt, owner, busy, x, y, colour, plot, timeout
  );

endinterface

// File: rtl/plot_arbiter_rr_picker.sv
// Combinational rotating-priority encoder: the first set request found
// starting at rr_ptr and wrapping round wins.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int OW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    rr_ptr,
  output logic             valid,
  output logic [N_REQ-1:0] onehot,
  output logic [OW-1:0]    idx
);

  // Scan from the far end back towards rr_ptr so the closest hit lands last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int c;
      c = (int'(rr_ptr) + k) % N_REQ;
      if (req[c[OW-1:0]]) begin
        valid = 1'b1;
        idx   = c[OW-1:0];
      end
    end
    onehot = valid ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin owner of the single vga_adapter plot port; the owning engine
// keeps it for a whole burst and its pixels pass through one register stage.
module plot_arbiter
  import finalproject_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int X_W      = PIX_X_W,
  parameter int Y_W      = PIX_Y_W,
  parameter int C_W      = PIX_C_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          reset,
  plot_arbiter_if.slave bus
);

  localparam int OW   = $clog2(N_REQ);
  localparam int HC_W = (MAX_HOLD >= 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic [1:0]       state;
  logic [OW-1:0]    rr_ptr;
  logic [HC_W-1:0]  hold_cnt;
  logic [N_REQ-1:0] gnt_q;
  logic [OW-1:0]    owner_q;
  logic             busy_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [C_W-1:0]   colour_q;
  logic             plot_q;
  logic             timeout_q;

  logic             pick_valid;
  logic [N_REQ-1:0] pick_onehot;
  logic [OW-1:0]    pick_idx;

  logic own_done;
  logic own_req;
  logic own_plot;
  logic hold_expired;

  rr_picker #(.N_REQ(N_REQ), .OW(OW)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign own_done     = bus.done[owner_q];
  assign own_req      = bus.req[owner_q];
  assign own_plot     = bus.pplot[owner_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // Exit priority in GRANT is done, then abort, then watchdog; only done
  // still forwards its final pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          plot_q <= 1'b0;
          if (pick_valid) begin
            gnt_q    <= pick_onehot;
            owner_q  <= pick_idx;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (!own_done && !own_req) begin
            plot_q <= 1'b0;
          end else if (!own_done && hold_expired) begin
            plot_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            plot_q <= own_plot;
            if (own_plot) begin
              x_q      <= bus.px[owner_q*X_W +: X_W];
              y_q      <= bus.py[owner_q*Y_W +: Y_W];
              colour_q <= bus.pcol[owner_q*C_W +: C_W];
            end
          end
          if (own_done || !own_req || hold_expired) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          plot_q <= 1'b0;
          rr_ptr <= (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          state  <= IDLE;
        end
        default: begin
          plot_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: directed scenarios plus random engine traffic, all
// checked cycle by cycle against a behavioural burst-level model.
module tb_plot_arbiter;
  import finalproject_pkg::*;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int MH = 16;
  localparam int OW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plot_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) bus ();

  plot_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = nobody owns, 1 = burst in progress, 2 = cool-down cycle.
  int            m_phase  = 0;
  int            m_ptr    = 0;
  int            m_cycles = 0;
  logic [OW-1:0] m_owner  = '0;
  logic [N-1:0]  e_gnt    = '0;
  logic          e_busy   = 1'b0;
  logic          e_plot   = 1'b0;
  logic          e_timeout = 1'b0;
  logic [XW-1:0] e_x      = '0;
  logic [YW-1:0] e_y      = '0;
  logic [CW-1:0] e_col    = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic [N-1:0] rq, dn, pp,
                           input logic [N*XW-1:0] xs, input logic [N*YW-1:0] ys,
                           input logic [N*CW-1:0] cs);
    int   pick;
    logic limit;
    e_timeout = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_cycles = 0; m_owner = '0;
      e_gnt = '0; e_busy = 1'b0; e_plot = 1'b0;
      e_x = '0; e_y = '0; e_col = '0;
    end else if (m_phase == 0) begin
      e_plot = 1'b0;
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && rq[OW'((m_ptr + k) % N)]) pick = (m_ptr + k) % N;
      if (pick >= 0) begin
        m_phase = 1; m_cycles = 0; m_owner = OW'(pick);
        e_gnt = N'(1) << pick;
        e_busy = 1'b1;
      end
    end else if (m_phase == 1) begin
      m_cycles++;
      limit = (m_cycles == MH);
      if (dn[m_owner] || (rq[m_owner] && !limit)) begin
        e_plot = pp[m_owner];
        if (pp[m_owner]) begin
          e_x   = xs[int'(m_owner)*XW +: XW];
          e_y   = ys[int'(m_owner)*YW +: YW];
          e_col = cs[int'(m_owner)*CW +: CW];
        end
      end else begin
        e_plot = 1'b0;
      end
      if (dn[m_owner] || !rq[m_owner] || limit) begin
        e_timeout = limit && rq[m_owner] && !dn[m_owner];
        e_gnt = '0; e_busy = 1'b0; m_phase = 2;
      end
    end else begin
      e_plot = 1'b0;
      m_ptr = (int'(m_owner) + 1) % N;
      m_phase = 0;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] rq, dn, pp,
                               input logic [N*XW-1:0] xs, input logic [N*YW-1:0] ys,
                               input logic [N*CW-1:0] cs);
    @(negedge clk);
    reset = rst; bus.req = rq; bus.done = dn; bus.pplot = pp;
    bus.px = xs; bus.py = ys; bus.pcol = cs;
    modelStep(rst, rq, dn, pp, xs, ys, cs);
    @(posedge clk);
    #1;
    checkOutput("gnt",     32'(bus.gnt),     32'(e_gnt));
    checkOutput("owner",   32'(bus.owner),   32'(m_owner));
    checkOutput("busy",    32'(bus.busy),    32'(e_busy));
    checkOutput("plot",    32'(bus.plot),    32'(e_plot));
    checkOutput("timeout", 32'(bus.timeout), 32'(e_timeout));
    checkOutput("x",       32'(bus.x),       32'(e_x));
    checkOutput("y",       32'(bus.y),       32'(e_y));
    checkOutput("colour",  32'(bus.colour),  32'(e_col));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    int             order[$];
    int             exp_order[5];
    int             gap, grants0, tcount, next_owner;
    logic           prev_on, finished, saw;
    logic [N-1:0]   dn, rq, pp, want;
    logic           rst;

    exp_order = '{0, 1, 2, 3, 0};
    bus.req = '0; bus.done = '0; bus.pplot = '0;
    bus.px = '0; bus.py = '0; bus.pcol = '0;

    $display("[TB] reset");
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_owner", 32'(bus.owner), 32'd0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);

    $display("[TB] single grant and latency");
    applyStimulus(1'b0, 4'b0100, '0, '0, '0, '0, '0);
    checkOutput("t1_gnt", 32'(bus.gnt), 32'b0100);
    checkOutput("t1_owner", 32'(bus.owner), 32'd2);
    checkOutput("t1_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 4'b0100, '0, 4'b0100, 32'd50 << 16, 28'd30 << 14, 12'd5 << 6);
    checkOutput("t1_x", 32'(bus.x), 32'd50);
    checkOutput("t1_y", 32'(bus.y), 32'd30);
    checkOutput("t1_colour", 32'(bus.colour), 32'd5);
    checkOutput("t1_plot", 32'(bus.plot), 32'd1);
    applyStimulus(1'b0, 4'b0100, 4'b0100, '0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);

    $display("[TB] round-robin fairness");
    doReset();
    gap = 0; prev_on = 1'b0;
    for (int it = 0; it < 40 && order.size() < 5; it++) begin
      dn = (m_phase == 1 && m_cycles == 3) ? (N'(1) << m_owner) : '0;
      applyStimulus(1'b0, 4'b1111, dn, '0, '0, '0, '0);
      if (bus.gnt != '0 && !prev_on) begin
        order.push_back(int'(bus.owner));
        if (order.size() > 1) checkOutput("rr_gap", 32'(gap), 32'd2);
        gap = 0;
      end
      if (bus.gnt == '0) gap++;
      prev_on = (bus.gnt != '0);
    end
    checkOutput("rr_count", 32'(order.size()), 32'd5);
    foreach (order[i]) checkOutput("rr_order", 32'(order[i]), 32'(exp_order[i]));

    $display("[TB] watchdog");
    doReset();
    grants0 = 0; tcount = 0; next_owner = -1;
    for (int it = 0; it < 25; it++) begin
      applyStimulus(1'b0, 4'b0011, '0, '0, '0, '0, '0);
      if (bus.gnt == 4'b0001) grants0++;
      if (bus.timeout) tcount++;
      if (tcount > 0 && bus.gnt != '0 && next_owner < 0) next_owner = int'(bus.owner);
    end
    checkOutput("wd_hold", 32'(grants0), 32'd16);
    checkOutput("wd_pulses", 32'(tcount), 32'd1);
    checkOutput("wd_next", 32'(next_owner), 32'd1);

    $display("[TB] done on the limit cycle");
    doReset();
    applyStimulus(1'b0, 4'b0001, '0, '0, '0, '0, '0);
    tcount = 0; saw = 1'b0; finished = 1'b0;
    for (int it = 0; it < 20; it++) begin
      if (!finished && m_cycles == MH - 1) begin
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 32'd77, '0, '0);
        finished = 1'b1;
      end else begin
        applyStimulus(1'b0, finished ? 4'b0000 : 4'b0001, '0, 4'b0001, 32'd10, '0, '0);
      end
      if (bus.timeout) tcount++;
      if (bus.plot && bus.x == 8'd77) saw = 1'b1;
    end
    checkOutput("lim_timeout", 32'(tcount), 32'd0);
    checkOutput("lim_last_px", 32'(saw), 32'd1);

    $display("[TB] abort");
    doReset();
    applyStimulus(1'b0, 4'b0001, '0, '0, '0, '0, '0);
    tcount = 0; saw = 1'b0;
    for (int it = 0; it < 7; it++) begin
      if (it == 3) applyStimulus(1'b0, 4'b0000, '0, 4'b0001, 32'd88, '0, '0);
      else applyStimulus(1'b0, (it < 3) ? 4'b0001 : 4'b0000, '0, 4'b0001, 32'd10, '0, '0);
      if (bus.timeout) tcount++;
      if (bus.plot && bus.x == 8'd88) saw = 1'b1;
    end
    checkOutput("abort_timeout", 32'(tcount), 32'd0);
    checkOutput("abort_px", 32'(saw), 32'd0);

    $display("[TB] reset mid-burst");
    doReset();
    for (int it = 0; it < 4; it++) applyStimulus(1'b0, 4'b1000, '0, 4'b1000, 32'hAB << 24, '0, '0);
    checkOutput("r6_owner_before", 32'(bus.owner), 32'd3);
    applyStimulus(1'b1, 4'b1000, '0, 4'b1000, '0, '0, '0);
    checkOutput("r6_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("r6_plot", 32'(bus.plot), 32'd0);
    checkOutput("r6_owner", 32'(bus.owner), 32'd0);
    checkOutput("r6_busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 4'b0010, '0, '0, '0, '0, '0);
    checkOutput("r6_regrant", 32'(bus.gnt), 32'b0010);

    $display("[TB] random traffic");
    doReset();
    want = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      rq = want;
      dn = N'($urandom & $urandom & $urandom);
      pp = N'($urandom);
      if (m_phase == 1) begin
        dn[m_owner] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 39) == 0) rq[m_owner] = 1'b0;
      end
      applyStimulus(rst, rq, dn, pp, $urandom, 28'($urandom), 12'($urandom));
      want = rst ? '0 : rq;
      if (m_phase == 2) want[m_owner] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!(m_phase == 1 && int'(m_owner) == i)) begin
          if (!want[i] && $urandom_range(0, 5) == 0) want[i] = 1'b1;
          else if (want[i] && $urandom_range(0, 29) == 0) want[i] = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA adapter plot port (x, y, colour, plot) between up to N_REQ drawing engines: card frame, score, symbol sprites, card cancel.
- Grants exclusive ownership to one engine for a whole sprite burst, using rotating (round-robin) priority.
- Forwards the owner's pixel stream through one register stage to the vga_adapter.
- Sits between the drawing engines and vga_adapter, replacing the per-state select mux inside the datapath.

Parameters:
- N_REQ, 4, number of requesting draw engines (2..8).
- X_W, 8, x coordinate width (160x120 mode).
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- MAX_HOLD, 1024, maximum cycles one owner may hold the port; 0 disables the watchdog.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  engine i requests the port for a burst; held high until done or abort.
- done  in  N_REQ  owner's last-pixel cycle indicator, single-cycle pulse.
- px  in  N_REQ*X_W  packed x per engine; engine i occupies bits [i*X_W +: X_W].
- py  in  N_REQ*Y_W  packed y per engine.
- pcol  in  N_REQ*C_W  packed colour per engine.
- pplot  in  N_REQ  per-engine pixel write strobe.
- gnt  out  N_REQ  one-hot grant, registered.
- owner  out  clog2(N_REQ)  index of current or last owner.
- busy  out  1  high while any engine holds the grant.
- x  out  X_W  to vga_adapter x.
- y  out  Y_W  to vga_adapter y.
- colour  out  C_W  to vga_adapter colour.
- plot  out  1  to vga_adapter plot.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset: all outputs are 0, gnt=0, owner=0, rr_ptr=0, hold_cnt=0, state=IDLE. Reset takes effect the cycle after it is sampled and overrides everything. A burst in flight is dropped with no done or timeout.
- States are IDLE, GRANT and RELEASE.
- IDLE, no request: gnt=0, busy=0, plot=0.
- IDLE, req!=0:
  - Pick the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - At the next edge: gnt[i]=1, owner=i, busy=1, hold_cnt=0, state=GRANT.
  - Grant latency is 1 cycle from req.
- GRANT:
  - Each cycle, x/y/colour/plot register the owner's px/py/pcol/pplot, so the pixel appears at the outputs 1 cycle after it is presented.
  - Non-owner pplot is ignored entirely.
  - hold_cnt increments every cycle.
- GRANT exits to RELEASE on the first of these:
  - done[owner]=1: that cycle's pixel is still forwarded.
  - req[owner]=0 (abort): that cycle's pixel is not forwarded.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with done[owner]=0: timeout=1 for exactly the following cycle.
- GRANT exit priority when events coincide: done beats timeout, so a burst ending exactly on the limit raises no timeout.
- RELEASE (one cycle): gnt=0, plot=0, busy=0, rr_ptr=(owner+1) mod N_REQ with wrap from N_REQ-1 to 0, then IDLE.
- Handover: done at cycle t, gnt low at t+1, earliest new gnt at t+3. There are no back-to-back grants without a dead cycle, which guarantees vga_adapter never sees mixed pixels.
- done or pplot from a non-owner, or done while in IDLE: ignored.
- req withdrawn in IDLE before it is sampled: no grant.
- x/y/colour hold their last value whenever plot=0.
- owner retains the last owner while idle.

Decomposition:
- Shared package (finalproject_pkg) holds:
  - plot_arbiter state encoding localparams (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - the coordinate widths X_W=8, Y_W=7, C_W=3 used by all draw engines;
  - the default MAX_HOLD.
- One sub-module, rr_picker: combinational rotating-priority encoder (req, rr_ptr in; valid and one-hot/index out), instantiated once. The FSM, hold counter and output registers stay in plot_arbiter.

Test Plan:
1. Single grant and latency: req=0100 at cycle 5 gives gnt=0100, owner=2, busy=1 at cycle 6. Engine 2 presents px=50, py=30, pcol=3'b101, pplot=1 at cycle 7. Outputs show x=50, y=30, colour=5, plot=1 at cycle 8.
2. Round-robin fairness: req=1111 held, each owner pulses done on its 4th GRANT cycle. Grant order is 0,1,2,3,0, with exactly 2 gnt=0 cycles between consecutive grants.
3. Isolation: engine 0 owns while engine 1 drives pplot=1, px=99 every cycle. Output plot and x track only engine 0 and never show 99.
4. Watchdog: MAX_HOLD=16, owner 0 never asserts done, req=0011. gnt drops after 16 GRANT cycles and timeout=1 for one cycle. The next grant goes to engine 1.
5. Coincidence and abort:
   - MAX_HOLD=16, done on the 16th GRANT cycle: timeout stays 0 and the last pixel is forwarded.
   - Owner drops req mid-burst: RELEASE follows, no timeout, and the abort-cycle pixel is not plotted.
6. Reset mid-burst: reset=1 at cycle 20 while engine 3 owns. At cycle 21 gnt=0, plot=0, owner=0, busy=0. After release, req=0010 gives gnt=0010 one cycle later.
